// File: rtl/dreg_arb_pkg.sv
// Shared definitions for the round-robin arbitrated D-register: state encoding,
// default sizes and the requester index-width helper.
package dreg_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dreg_bank.sv
// WIDTH-bit D-register bank with load enable and async active-high reset.
// q_bar is derived from q, so it also reads all ones while reset is held.
module dreg_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_bar_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o     = q_q;
  assign q_bar_o = ~q_q;

endmodule

// File: rtl/dreg_rr_arbiter.sv
// Round-robin arbiter sharing one D-register among NREQ requesters.
// Optional owner lock enabled by defining DREG_ARB_LOCK_EN.
module dreg_rr_arbiter
  import dreg_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = idx_w(NREQ)
`ifdef DREG_ARB_LOCK_EN
  , parameter int MAX_LOCK = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] d,
`ifdef DREG_ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      q_bar,
  output logic [IDW-1:0]        owner,
  output logic                  valid
);

  state_e            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    owner_q;
  logic              valid_q;
  logic [IDW-1:0]    win_rr, win_sel, idx_v;
  logic              found;
  logic              any_req;
  logic [WIDTH-1:0]  d_arr [NREQ];

  assign any_req = |req;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign d_arr[i] = d[i*WIDTH +: WIDTH];
  end

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_rr = ptr_q;
    found  = 1'b0;
    idx_v  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx_v]) begin
        found  = 1'b1;
        win_rr = idx_v;
      end
    end
  end

`ifdef DREG_ARB_LOCK_EN
  logic [7:0] lock_cnt_q;
  logic       lock_hold;

  assign lock_hold = valid_q && req[owner_q] && lock[owner_q] &&
                     (lock_cnt_q < 8'(MAX_LOCK));
  assign win_sel   = lock_hold ? owner_q : win_rr;

  // Counts consecutive grants to the current owner; an idle cycle or a new owner restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
    end else if (!any_req) begin
      lock_cnt_q <= '0;
    end else if (valid_q && (win_sel == owner_q)) begin
      if (lock_cnt_q != 8'hFF) lock_cnt_q <= lock_cnt_q + 8'd1;
    end else begin
      lock_cnt_q <= 8'd1;
    end
  end
`else
  assign win_sel = win_rr;
`endif

  assign ptr_d = (win_sel == IDW'(NREQ - 1)) ? '0 : win_sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
    end else if (any_req) begin
      state_q <= ST_GRANT;
      gnt_q   <= NREQ'(1) << win_sel;
      ptr_q   <= ptr_d;
      owner_q <= win_sel;
      valid_q <= 1'b1;
    end else begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
    end
  end

  dreg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (any_req),
    .d_i     (d_arr[win_sel]),
    .q_o     (q),
    .q_bar_o (q_bar)
  );

  assign gnt   = (state_q == ST_GRANT) ? gnt_q : '0;
  assign owner = owner_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_dreg_rr_arbiter.sv
// Directed bench for dreg_rr_arbiter (NREQ=4, WIDTH=8); the lock scenario
// is only built when DREG_ARB_LOCK_EN is defined.
module tb_dreg_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] d;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  q_bar;
  logic [1:0]  owner;
  logic        valid;
`ifdef DREG_ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  int tests_run;
  int tests_failed;

  dreg_rr_arbiter #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .d     (d),
`ifdef DREG_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .q     (q),
    .q_bar (q_bar),
    .owner (owner),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; d = '0;
    repeat (2) @(negedge clk);
    tests_run += 5;
    if (q !== 8'h00)     begin tests_failed++; $display("FAIL reset_q: got %h want 00", q); end
    if (q_bar !== 8'hFF) begin tests_failed++; $display("FAIL reset_qbar: got %h want ff", q_bar); end
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    if (owner !== 2'd0)  begin tests_failed++; $display("FAIL reset_owner: got %0d want 0", owner); end
    if (valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
    rst = 1'b0;
    req = 4'b0001; d = {24'h0, 8'hA5};
    @(negedge clk);
    tests_run++;
    if (q !== 8'hA5) begin tests_failed++; $display("FAIL pre_reset_q: got %h want a5", q); end
    req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    tests_run += 4;
    if (q !== 8'h00)     begin tests_failed++; $display("FAIL async_reset_q: got %h want 00", q); end
    if (q_bar !== 8'hFF) begin tests_failed++; $display("FAIL async_reset_qbar: got %h want ff", q_bar); end
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL async_reset_gnt: got %b want 0000", gnt); end
    if (valid !== 1'b0)  begin tests_failed++; $display("FAIL async_reset_valid: got %b want 0", valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_g = 4'b0001 << (i % 4);
      exp_q = 8'h10 + 8'(i % 4);
      tests_run += 2;
      if (gnt !== exp_g) begin tests_failed++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, gnt, exp_g); end
      if (q !== exp_q)   begin tests_failed++; $display("FAIL contention_q[%0d]: got %h want %h", i, q, exp_q); end
    end
    req = 4'b0000;
    @(negedge clk);
    tests_run += 2;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL contention_idle_gnt: got %b want 0000", gnt); end
    if (q !== 8'h13)     begin tests_failed++; $display("FAIL contention_idle_q: got %h want 13", q); end
  endtask

  task automatic test_single();
    req = 4'b0100; d = {8'h00, 8'h3C, 8'h00, 8'h00};
    @(negedge clk);
    req = 4'b0000; d = '0;
    tests_run += 5;
    if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    if (q !== 8'h3C)     begin tests_failed++; $display("FAIL single_q: got %h want 3c", q); end
    if (q_bar !== 8'hC3) begin tests_failed++; $display("FAIL single_qbar: got %h want c3", q_bar); end
    if (owner !== 2'd2)  begin tests_failed++; $display("FAIL single_owner: got %0d want 2", owner); end
    if (valid !== 1'b1)  begin tests_failed++; $display("FAIL single_valid: got %b want 1", valid); end
    @(negedge clk);
    tests_run += 3;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL single_release_gnt: got %b want 0000", gnt); end
    if (q !== 8'h3C)     begin tests_failed++; $display("FAIL single_hold_q: got %h want 3c", q); end
    if (owner !== 2'd2)  begin tests_failed++; $display("FAIL single_hold_owner: got %0d want 2", owner); end
  endtask

  // Pointer sits at 3 here, so the first grant wraps to requester 0.
  task automatic test_wrap_skip();
    logic [3:0] exp_g [3];
    logic [7:0] exp_q [3];
    exp_g = '{4'b0001, 4'b0100, 4'b0001};
    exp_q = '{8'hA0, 8'hA2, 8'hA0};
    d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run += 2;
      if (gnt !== exp_g[i]) begin tests_failed++; $display("FAIL wrap_gnt[%0d]: got %b want %b", i, gnt, exp_g[i]); end
      if (q !== exp_q[i])   begin tests_failed++; $display("FAIL wrap_q[%0d]: got %h want %h", i, q, exp_q[i]); end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  // Pointer is 1: requester 1 alone wins every cycle, capturing fresh data each edge.
  task automatic test_back_to_back();
    logic [7:0] v;
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      v = 8'h51 + 8'(i);
      d = {8'h00, 8'h00, v, 8'h00};
      @(negedge clk);
      tests_run += 2;
      if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL b2b_gnt[%0d]: got %b want 0010", i, gnt); end
      if (q !== v)         begin tests_failed++; $display("FAIL b2b_q[%0d]: got %h want %h", i, q, v); end
    end
    req = 4'b1000; d = {8'h77, 24'h0};
    @(negedge clk);
    tests_run += 2;
    if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL b2b_last_gnt: got %b want 1000", gnt); end
    if (owner !== 2'd3)  begin tests_failed++; $display("FAIL b2b_last_owner: got %0d want 3", owner); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  // Pointer is 0: grants 0,1,2, then reset; without the pointer clearing the next grant would go to 3.
  task automatic test_reset_contention();
    d = {8'h23, 8'h22, 8'h21, 8'h20};
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (gnt !== (4'b0001 << i)) begin tests_failed++; $display("FAIL rstc_gnt[%0d]: got %b want %b", i, gnt, 4'b0001 << i); end
    end
    #2 rst = 1'b1;
    #1;
    tests_run += 4;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL rstc_cut_gnt: got %b want 0000", gnt); end
    if (q !== 8'h00)     begin tests_failed++; $display("FAIL rstc_q: got %h want 00", q); end
    if (valid !== 1'b0)  begin tests_failed++; $display("FAIL rstc_valid: got %b want 0", valid); end
    if (owner !== 2'd0)  begin tests_failed++; $display("FAIL rstc_owner: got %0d want 0", owner); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL rstc_first_gnt: got %b want 0001", gnt); end
    if (q !== 8'h20)     begin tests_failed++; $display("FAIL rstc_first_q: got %h want 20", q); end
    req = 4'b0000;
    @(negedge clk);
  endtask

`ifdef DREG_ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_g [6];
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d = {8'h00, 8'h00, 8'h31, 8'h30};
    lock = 4'b0001;
    req = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (gnt !== exp_g[i]) begin tests_failed++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, gnt, exp_g[i]); end
    end
    req = 4'b0000; lock = 4'b0000;
    @(negedge clk);
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
`ifdef DREG_ARB_LOCK_EN
    lock = 4'b0000;
`endif
    test_reset();
    test_contention();
    test_single();
    test_wrap_skip();
    test_back_to_back();
    test_reset_contention();
`ifdef DREG_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dreg_rr_arbiter.md
Name: dreg_rr_arbiter

Overview:
- Shares one WIDTH-bit D-register, built from the team's D flip-flop cells with q/q_bar outputs, among NREQ requesters.
- Each cycle, a round-robin arbiter picks one requester and loads its data into the register. The requester receives a one-cycle grant pulse.
- Sits between multiple producer blocks and a single shared state register, e.g. a mode or config latch.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width.
- IDW, 2, requester index width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request, level.
- d  in  NREQ*WIDTH  requester data; slice i is d[i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant pulse, registered.
- q  out  WIDTH  shared register value.
- q_bar  out  WIDTH  bitwise inverse of q, always.
- owner  out  IDW  index of the last requester that wrote q.
- valid  out  1  q has been written at least once since reset.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - gnt=0, q=0, q_bar=all ones, owner=0, valid=0.
  - Round-robin pointer ptr=0, FSM in IDLE.
- FSM states:
  - IDLE: no grant issued.
  - GRANT: grant issued this cycle.
- Transitions, evaluated at the rising edge:
  - From either state: if |req, go to GRANT; otherwise go to IDLE.
- Winner selection:
  - The winner w is the first index with req set, searching ptr, ptr+1, ..., ptr+NREQ-1 modulo NREQ.
  - Selection is combinational from req and ptr sampled at the edge.
- Latency: req sampled at edge N gives, after edge N:
  - gnt[w]=1 for exactly one cycle.
  - q=d[w] as sampled at edge N.
  - owner=w, valid=1.
  - ptr=(w+1) mod NREQ.
- Write data comes from the same edge at which req was sampled; d need not stay stable after that edge.
- Handshake:
  - A requester drops req in the cycle it sees gnt.
  - If req is still high at the next edge, it re-competes and is treated as a new request (back-to-back grants are possible).
  - req must not be qualified combinationally by gnt.
- No request: q, owner and valid hold; gnt=0; ptr holds.
- Fairness: with all req held high, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- Wrap-around: when w=NREQ-1, ptr returns to 0.
- Single persistent requester: it is granted every cycle.
- Reset mid-operation: on rst assertion, all state clears immediately. Any grant pulse in flight is cut short, and the bench must not count it as a write.
- q_bar is always ~q, including during reset.

Optional Feature:
- Macro: DREG_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (NREQ bits) and parameter MAX_LOCK (default 4).
  - If the current owner holds req[owner] and lock[owner] high, it keeps winning regardless of ptr.
  - The lock lasts for up to MAX_LOCK consecutive grants. The counter resets on any grant to a different requester or on an idle cycle.
  - After MAX_LOCK grants, arbitration resumes from owner+1.
  - The lock counter resets to 0 on rst.
- Undefined: no lock port, no counter; pure round-robin.

Decomposition:
- Package dreg_arb_pkg holds:
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Default NREQ/WIDTH constants.
  - Index-width helper function.
- One natural sub-module: dreg_bank.
  - WIDTH-bit register with async active-high reset and load enable, producing q and q_bar.
  - It is instantiated once.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with q=8'hA5 -> q=0, q_bar=8'hFF, gnt=0, valid=0 immediately, without waiting for an edge.
- Single request: req=4'b0100, d slice 2=8'h3C -> next cycle gnt=4'b0100, q=8'h3C, owner=2, valid=1. Release req -> gnt=0 and q holds 8'h3C.
- Full contention: req=4'b1111 held for 8 cycles, slices 8'h10/8'h11/8'h12/8'h13 -> gnt sequence 0001,0010,0100,1000 repeated; q follows 10,11,12,13.
- Wrap and skip: ptr=3 with req=4'b0101 -> grant to 0 then 2, then 0 again; requesters 1 and 3 are never granted.
- Reset during contention: rst pulses while req=4'b1111 at the third grant -> ptr=0, and the first grant after release goes to requester 0.
- Lock (DREG_ARB_LOCK_EN, MAX_LOCK=4): req=4'b0011, lock=4'b0001 -> requester 0 granted 4 times, then 1, then 0 again.
